weight_buf_sequencer: RTL and testbench

- Controller that sequences a single-port weight/feature buffer of CNT_DEPTH words for one LeNet layer engine.
- Runs a load phase that accepts exactly CNT_DEPTH writes, then on start issues i_num_pass full read sweeps (address 0..CNT_DEPTH-1, wrapping) gated by a clock enable.
- Reports first/last markers per sweep and a one-cycle completion pulse.
- Sits between the AXI4-Lite register/handshake front end and the buffer/PE array.

---
 rtl/weight_buf_sequencer_pkg.sv | 14 +
 rtl/weight_buf_sequencer_addr_wrap_counter.sv | 27 ++
 rtl/weight_buf_sequencer.sv | 146 ++++++++++++++
 tb/tb_weight_buf_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buf_sequencer_pkg.sv
// Shared state encoding for the weight buffer sequencer.
package weight_buf_sequencer_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOADED = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/weight_buf_sequencer_addr_wrap_counter.sv
// Buffer address counter: counts 0..CNT_DEPTH-1 on enable and wraps to 0.
// A synchronous clear takes priority over the enable.
module weight_buf_sequencer_addr_wrap_counter #(
    parameter int CNT_WIDTH = 4,
    parameter int CNT_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tc
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CNT_DEPTH - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/weight_buf_sequencer.sv
// Sequences one load of CNT_DEPTH words into the weight buffer, then repeated
// read sweeps over it under a clock enable.
//
//   state    | meaning
//   S_IDLE   | buffer empty, waiting for i_load
//   S_LOAD   | accepting writes until CNT_DEPTH words are stored
//   S_LOADED | buffer full, waiting for i_start (or i_load to reload)
//   S_RUN    | issuing read sweeps while i_ce is high
//   S_DONE   | one-cycle completion pulse, then back to S_LOADED
module weight_buf_sequencer
    import weight_buf_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH  = 4,
    parameter int CNT_DEPTH  = 16,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    output logic                  o_wr_en,
    output logic [CNT_WIDTH-1:0]  o_wr_addr,
    input  logic                  i_start,
    input  logic [PASS_WIDTH-1:0] i_num_pass,
    input  logic                  i_ce,
    input  logic                  i_user_reset,
    output logic                  o_rd_en,
    output logic [CNT_WIDTH-1:0]  o_rd_addr,
    output logic                  o_rd_first,
    output logic                  o_rd_last,
    output logic                  o_loaded,
    output logic                  o_busy,
    output logic                  o_done
);

    state_t                state;
    state_t                state_next;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic [PASS_WIDTH-1:0] last_pass;
    logic                  wr_tc;
    logic                  rd_tc;
    logic                  is_last_pass;
    logic                  start_ok;
    logic                  load_ok;
    logic                  final_read;

    // i_start beats i_load when both arrive in S_LOADED.
    assign start_ok = (state == S_LOADED) && i_start && !i_user_reset;
    assign load_ok  = i_load && !i_user_reset &&
                      ((state == S_IDLE) || ((state == S_LOADED) && !i_start));

    assign o_wr_ready   = (state == S_LOAD);
    assign o_wr_en      = i_wr_valid && o_wr_ready;
    assign o_rd_en      = (state == S_RUN) && i_ce;
    assign is_last_pass = (pass_cnt == last_pass);
    assign final_read   = o_rd_en && rd_tc && is_last_pass;
    assign o_rd_first   = o_rd_en && (o_rd_addr == '0);
    assign o_rd_last    = final_read;
    assign o_busy       = (state == S_LOAD) || (state == S_RUN);
    assign o_done       = (state == S_DONE);

    weight_buf_sequencer_addr_wrap_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .CNT_DEPTH (CNT_DEPTH)
    ) u_wr_addr (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_user_reset || load_ok),
        .en    (o_wr_en),
        .count (o_wr_addr),
        .tc    (wr_tc)
    );

    weight_buf_sequencer_addr_wrap_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .CNT_DEPTH (CNT_DEPTH)
    ) u_rd_addr (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_user_reset || start_ok),
        .en    (o_rd_en),
        .count (o_rd_addr),
        .tc    (rd_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pass count 0 is run as a single pass; the latched index bounds pass_cnt.
    always_ff @(posedge clk) begin
        if (rst || i_user_reset) begin
            pass_cnt  <= '0;
            last_pass <= '0;
            o_loaded  <= 1'b0;
        end else begin
            if (start_ok) begin
                pass_cnt  <= '0;
                last_pass <= (i_num_pass == '0) ? '0 : i_num_pass - PASS_WIDTH'(1);
            end else if (o_rd_en && rd_tc && !is_last_pass) begin
                pass_cnt <= pass_cnt + PASS_WIDTH'(1);
            end

            if (load_ok) begin
                o_loaded <= 1'b0;
            end else if (o_wr_en && wr_tc) begin
                o_loaded <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (i_user_reset) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_load) state_next = S_LOAD;
                end
                S_LOAD: begin
                    if (o_wr_en && wr_tc) state_next = S_LOADED;
                end
                S_LOADED: begin
                    if (i_start)     state_next = S_RUN;
                    else if (i_load) state_next = S_LOAD;
                end
                S_RUN: begin
                    if (final_read) state_next = S_DONE;
                end
                S_DONE: begin
                    state_next = S_LOADED;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_buf_sequencer.sv
// Directed bench for weight_buf_sequencer with hand-computed expectations.
module tb_weight_buf_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_load;
    logic       i_wr_valid;
    logic       o_wr_ready;
    logic       o_wr_en;
    logic [3:0] o_wr_addr;
    logic       i_start;
    logic [7:0] i_num_pass;
    logic       i_ce;
    logic       i_user_reset;
    logic       o_rd_en;
    logic [3:0] o_rd_addr;
    logic       o_rd_first;
    logic       o_rd_last;
    logic       o_loaded;
    logic       o_busy;
    logic       o_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    weight_buf_sequencer #(
        .CNT_WIDTH  (4),
        .CNT_DEPTH  (16),
        .PASS_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_load       (i_load),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .i_start      (i_start),
        .i_num_pass   (i_num_pass),
        .i_ce         (i_ce),
        .i_user_reset (i_user_reset),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .o_rd_first   (o_rd_first),
        .o_rd_last    (o_rd_last),
        .o_loaded     (o_loaded),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic do_load();
        i_load = 1'b1;
        to_pos();
        i_load     = 1'b0;
        i_wr_valid = 1'b1;
        repeat (16) to_pos();
        i_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_load = 1'b1; i_wr_valid = 1'b1; i_start = 1'b1;
        i_ce = 1'b1; i_num_pass = 8'd5; i_user_reset = 1'b0;
        to_pos();
        to_pos();
        to_neg();
        n_cmp++;
        if ({o_wr_ready, o_wr_en, o_wr_addr, o_rd_en, o_rd_addr, o_rd_first,
             o_rd_last, o_loaded, o_busy, o_done} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs got wr_en=%b wr_addr=%0d rd_en=%b rd_addr=%0d loaded=%b busy=%b done=%b exp all 0",
                     o_wr_en, o_wr_addr, o_rd_en, o_rd_addr, o_loaded, o_busy, o_done);
        end
        to_pos();
        rst = 1'b0; i_load = 1'b0; i_wr_valid = 1'b0; i_start = 1'b0;
        i_ce = 1'b0; i_num_pass = 8'd0;
    endtask

    task automatic test_load();
        i_load = 1'b1;
        to_neg();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++; $display("FAIL load_idle_busy got %b exp 0", o_busy);
        end
        to_pos();
        i_load = 1'b0; i_wr_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            to_neg();
            n_cmp++;
            if (o_wr_en !== 1'b1 || o_wr_addr !== 4'(k) || o_loaded !== 1'b0 || o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL load_write k=%0d got en=%b addr=%0d loaded=%b busy=%b exp en=1 addr=%0d loaded=0 busy=1",
                         k, o_wr_en, o_wr_addr, o_loaded, o_busy, k);
            end
            to_pos();
        end
        to_neg();
        n_cmp++;
        if (o_loaded !== 1'b1 || o_busy !== 1'b0 || o_wr_en !== 1'b0 || o_wr_addr !== 4'd0) begin
            n_err++;
            $display("FAIL load_complete got loaded=%b busy=%b wr_en=%b addr=%0d exp 1 0 0 0",
                     o_loaded, o_busy, o_wr_en, o_wr_addr);
        end
        to_pos();
        i_wr_valid = 1'b0;
    endtask

    task automatic test_gapped_load();
        int nw;
        logic v;
        nw = 0;
        i_num_pass = 8'd1;
        i_load = 1'b1;
        to_neg();
        n_cmp++;
        if (o_loaded !== 1'b1) begin
            n_err++; $display("FAIL reload_pulse_loaded got %b exp 1", o_loaded);
        end
        to_pos();
        i_load = 1'b0;
        for (int j = 0; j < 32; j++) begin
            v          = (j % 2 == 0);
            i_wr_valid = v;
            i_start    = !v && (j < 31);
            i_load     = !v && (j < 31);
            to_neg();
            n_cmp++;
            if (o_wr_en !== (v && nw < 16) || o_wr_addr !== 4'(nw % 16) ||
                o_loaded !== (nw == 16) || o_rd_en !== 1'b0) begin
                n_err++;
                $display("FAIL gapped_load j=%0d got en=%b addr=%0d loaded=%b rd_en=%b exp en=%b addr=%0d loaded=%b rd_en=0",
                         j, o_wr_en, o_wr_addr, o_loaded, o_rd_en, v && nw < 16, nw % 16, nw == 16);
            end
            to_pos();
            if (v) nw++;
        end
        i_wr_valid = 1'b0; i_start = 1'b0; i_load = 1'b0;
    endtask

    task automatic test_run3();
        int nr;
        int nfirst;
        int nlast;
        int ndone;
        int done_c;
        nr = 0; nfirst = 0; nlast = 0; ndone = 0; done_c = -1;
        i_num_pass = 8'd3; i_start = 1'b1; i_ce = 1'b1;
        to_neg();
        n_cmp++;
        if (o_rd_en !== 1'b0) begin
            n_err++; $display("FAIL run3_start_cycle_rd_en got %b exp 0", o_rd_en);
        end
        to_pos();
        i_start = 1'b0; i_num_pass = 8'd0;
        for (int c = 1; c <= 60; c++) begin
            to_neg();
            n_cmp++;
            if (o_rd_en !== (c <= 48) || o_busy !== (c <= 48)) begin
                n_err++;
                $display("FAIL run3_en c=%0d got rd_en=%b busy=%b exp %b", c, o_rd_en, o_busy, c <= 48);
            end
            if (c <= 48) begin
                n_cmp++;
                if (o_rd_addr !== 4'((c - 1) % 16) || o_rd_first !== ((c - 1) % 16 == 0) ||
                    o_rd_last !== (c == 48)) begin
                    n_err++;
                    $display("FAIL run3_read c=%0d got addr=%0d first=%b last=%b exp addr=%0d first=%b last=%b",
                             c, o_rd_addr, o_rd_first, o_rd_last, (c - 1) % 16, (c - 1) % 16 == 0, c == 48);
                end
            end
            if (o_rd_en)    nr++;
            if (o_rd_first) nfirst++;
            if (o_rd_last)  nlast++;
            if (o_done) begin
                ndone++;
                done_c = c;
            end
            to_pos();
        end
        n_cmp++;
        if (nr !== 48 || nfirst !== 3 || nlast !== 1) begin
            n_err++;
            $display("FAIL run3_totals got reads=%0d firsts=%0d lasts=%0d exp 48 3 1", nr, nfirst, nlast);
        end
        n_cmp++;
        if (ndone !== 1 || done_c !== 49) begin
            n_err++;
            $display("FAIL run3_done got count=%0d cycle=%0d exp 1 at 49", ndone, done_c);
        end
        to_neg();
        n_cmp++;
        if (o_loaded !== 1'b1 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL run3_after got loaded=%b busy=%b exp 1 0", o_loaded, o_busy);
        end
        to_pos();
    endtask

    task automatic test_pass0_ce_toggle();
        int  nr;
        logic exp_en;
        nr = 0;
        i_num_pass = 8'd0; i_start = 1'b1; i_ce = 1'b1;
        to_pos();
        i_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            i_ce   = (c % 2 == 1);
            exp_en = (c <= 31) && (c % 2 == 1);
            to_neg();
            n_cmp++;
            if (o_rd_en !== exp_en || o_done !== (c == 32)) begin
                n_err++;
                $display("FAIL pass0_en c=%0d got rd_en=%b done=%b exp %b %b", c, o_rd_en, o_done, exp_en, c == 32);
            end
            if (c <= 31) begin
                n_cmp++;
                if (o_rd_addr !== 4'(nr) ||
                    (exp_en && (o_rd_last !== (nr == 15) || o_rd_first !== (nr == 0)))) begin
                    n_err++;
                    $display("FAIL pass0_read c=%0d got addr=%0d first=%b last=%b exp addr=%0d first=%b last=%b",
                             c, o_rd_addr, o_rd_first, o_rd_last, nr, exp_en && nr == 0, exp_en && nr == 15);
                end
            end
            to_pos();
            if (exp_en) nr++;
        end
        i_ce = 1'b0;
    endtask

    task automatic test_abort();
        int bad;
        bad = 0;
        i_num_pass = 8'd3; i_start = 1'b1; i_ce = 1'b1;
        to_pos();
        i_start = 1'b0;
        repeat (22) to_pos();
        i_user_reset = 1'b1;
        to_neg();
        n_cmp++;
        if (o_rd_en !== 1'b1 || o_rd_addr !== 4'd6) begin
            n_err++; $display("FAIL abort_read7 got rd_en=%b addr=%0d exp 1 6", o_rd_en, o_rd_addr);
        end
        to_pos();
        i_user_reset = 1'b0;
        to_neg();
        n_cmp++;
        if (o_rd_en !== 1'b0 || o_loaded !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_next got rd_en=%b loaded=%b busy=%b done=%b exp 0 0 0 0",
                     o_rd_en, o_loaded, o_busy, o_done);
        end
        to_pos();
        for (int c = 25; c <= 64; c++) begin
            i_start = (c == 25) || (c == 40);
            to_neg();
            if (o_rd_en || o_done || o_loaded) bad++;
            to_pos();
        end
        i_start = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad);
        end
        do_load();
        to_neg();
        n_cmp++;
        if (o_loaded !== 1'b1) begin
            n_err++; $display("FAIL abort_reload got loaded=%b exp 1", o_loaded);
        end
        to_pos();
    endtask

    task automatic test_priority();
        i_num_pass = 8'd1; i_start = 1'b1; i_load = 1'b1; i_ce = 1'b1;
        to_pos();
        i_start = 1'b0; i_load = 1'b0;
        to_neg();
        n_cmp++;
        if (o_rd_en !== 1'b1 || o_rd_addr !== 4'd0 || o_rd_first !== 1'b1 ||
            o_loaded !== 1'b1 || o_wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL prio_start_wins got rd_en=%b addr=%0d first=%b loaded=%b wr_ready=%b exp 1 0 1 1 0",
                     o_rd_en, o_rd_addr, o_rd_first, o_loaded, o_wr_ready);
        end
        to_pos();
        repeat (4) to_pos();
        rst = 1'b1;
        to_pos();
        rst = 1'b0;
        to_neg();
        n_cmp++;
        if (o_rd_en !== 1'b0 || o_rd_addr !== 4'd0 || o_loaded !== 1'b0 ||
            o_busy !== 1'b0 || o_done !== 1'b0 || o_rd_first !== 1'b0) begin
            n_err++;
            $display("FAIL prio_rst_in_run got rd_en=%b addr=%0d loaded=%b busy=%b done=%b exp all 0",
                     o_rd_en, o_rd_addr, o_loaded, o_busy, o_done);
        end
        to_pos();
        i_ce = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_load = 1'b0; i_wr_valid = 1'b0; i_start = 1'b0;
        i_num_pass = 8'd0; i_ce = 1'b0; i_user_reset = 1'b0;
        test_reset();
        test_load();
        test_gapped_load();
        test_run3();
        test_pass0_ce_toggle();
        test_abort();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
